// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared state encodings and constants for the iterative divider.
package div_seq_pkg;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } divState_t;
  localparam int DIV_ITER = 32;
  localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on {r, q}.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   rNext,
  output logic [WIDTH-1:0] qNext
);
  logic [WIDTH+1:0] wide;
  logic [WIDTH+1:0] trial;
  always_comb begin
    wide  = {r, q[WIDTH-1]};
    trial = wide - {2'b0, d};
    rNext = (WIDTH+1)'(trial[WIDTH+1] ? wide : trial);
    qNext = {q[WIDTH-2:0], ~trial[WIDTH+1]};
  end
endmodule

// File: rtl/div_seq.sv
// div_seq: iterative signed/unsigned divider, one restoring step per cycle,
// stalling the pipeline while busy and presenting {remainder, quotient}.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               flush,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               stall,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);
  divState_t state, stateNext;
  logic [5:0] counter;
  logic [WIDTH:0] rReg, stepR;
  logic [WIDTH-1:0] qReg, stepQ, dReg, absDividend, absDivisor, quoFix, remFix;
  logic negQ, negR, doneReg, accept, divZero, lastStep;
  div_step #(.WIDTH(WIDTH)) uStep (
    .r(rReg),
    .q(qReg),
    .d(dReg),
    .rNext(stepR),
    .qNext(stepQ)
  );
  always_comb begin
    accept      = state == DIV_IDLE & start & ~flush;
    divZero     = divisor == '0;
    lastStep    = state == DIV_RUN & counter == 6'(DIV_ITER - 1);
    absDividend = signed_div & dividend[WIDTH-1] ? -dividend : dividend;
    absDivisor  = signed_div & divisor[WIDTH-1] ? -divisor : divisor;
    quoFix      = negQ ? -stepQ : stepQ;
    remFix      = negR ? -stepR[WIDTH-1:0] : stepR[WIDTH-1:0];
    stateNext   = flush ? DIV_IDLE
                : state == DIV_IDLE ? (accept ? (divZero ? DIV_DONE : DIV_RUN) : DIV_IDLE)
                : state == DIV_RUN ? (lastStep ? DIV_DONE : DIV_RUN)
                : DIV_IDLE;
    stall       = ~rst & (accept | state == DIV_RUN);
    busy        = state != DIV_IDLE;
    done        = doneReg & ~flush;
  end
  // result is written on the edge into DONE so it is valid alongside the done strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DIV_IDLE;
      counter <= '0;
      doneReg <= 1'b0;
      result  <= '0;
      rReg    <= '0;
      qReg    <= '0;
      dReg    <= '0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
    end else begin
      state   <= stateNext;
      doneReg <= ~flush & (lastStep | (accept & divZero));
      if (accept) begin
        counter <= '0;
        rReg    <= '0;
        qReg    <= absDividend;
        dReg    <= absDivisor;
        negQ    <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        negR    <= signed_div & dividend[WIDTH-1];
      end else if (state == DIV_RUN) begin
        counter <= counter + 6'd1;
        rReg    <= stepR;
        qReg    <= stepQ;
      end
      if (~flush & lastStep)
        result <= {remFix, quoFix};
      else if (accept & divZero)
        result <= {dividend, WIDTH'(DIV_ZERO_QUO)};
    end
  end
endmodule
